// File: rtl/swap_gate.sv
// Qubit-0/qubit-2 SWAP stage of the 3-qubit QFT: exchanges |001><->|100> and |011><->|110>.
// One registered stage, no backpressure; invariant amplitudes are routed around this block.
`ifndef TOTAL_WIDTH
`define TOTAL_WIDTH 16
`endif
`ifndef FRAC_WIDTH
`define FRAC_WIDTH 4
`endif

module swap_gate #(
  parameter int TOTAL_WIDTH = `TOTAL_WIDTH,
  parameter int FRAC_WIDTH  = `FRAC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [TOTAL_WIDTH-1:0] in_001_r,
  input  logic [TOTAL_WIDTH-1:0] in_001_i,
  input  logic [TOTAL_WIDTH-1:0] in_100_r,
  input  logic [TOTAL_WIDTH-1:0] in_100_i,
  input  logic [TOTAL_WIDTH-1:0] in_011_r,
  input  logic [TOTAL_WIDTH-1:0] in_011_i,
  input  logic [TOTAL_WIDTH-1:0] in_110_r,
  input  logic [TOTAL_WIDTH-1:0] in_110_i,
  output logic                   out_valid,
  output logic [TOTAL_WIDTH-1:0] out_001_r,
  output logic [TOTAL_WIDTH-1:0] out_001_i,
  output logic [TOTAL_WIDTH-1:0] out_100_r,
  output logic [TOTAL_WIDTH-1:0] out_100_i,
  output logic [TOTAL_WIDTH-1:0] out_011_r,
  output logic [TOTAL_WIDTH-1:0] out_011_i,
  output logic [TOTAL_WIDTH-1:0] out_110_r,
  output logic [TOTAL_WIDTH-1:0] out_110_i
);

  // The fixed-point format only matters downstream; reject a nonsensical one at elaboration.
  generate
    if (FRAC_WIDTH < 0 || FRAC_WIDTH >= TOTAL_WIDTH) begin : g_bad_format
      $error("swap_gate: FRAC_WIDTH must lie in [0, TOTAL_WIDTH)");
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_001_r <= '0;
      out_001_i <= '0;
      out_100_r <= '0;
      out_100_i <= '0;
      out_011_r <= '0;
      out_011_i <= '0;
      out_110_r <= '0;
      out_110_i <= '0;
    end else begin
      out_valid <= in_valid;
      // Data holds when no vector arrives, so the last result stays readable.
      if (in_valid) begin
        out_001_r <= in_100_r;
        out_001_i <= in_100_i;
        out_100_r <= in_001_r;
        out_100_i <= in_001_i;
        out_011_r <= in_110_r;
        out_011_i <= in_110_i;
        out_110_r <= in_011_r;
        out_110_i <= in_011_i;
      end
    end
  end

endmodule

// File: tb/tb_swap_gate.sv
// Directed bench for swap_gate with a queue scoreboard of expected swapped vectors.
module tb_swap_gate;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] a001_r, a001_i, a100_r, a100_i, a011_r, a011_i, a110_r, a110_i;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_001_r, in_001_i, in_100_r, in_100_i, in_011_r, in_011_i, in_110_r, in_110_i;
  logic out_valid;
  logic [W-1:0] out_001_r, out_001_i, out_100_r, out_100_i, out_011_r, out_011_i, out_110_r, out_110_i;

  int errors = 0;
  int checks = 0;
  vec_t exp_q[$];
  vec_t last_out;

  always #5 clk = ~clk;

  swap_gate #(.TOTAL_WIDTH(W), .FRAC_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_001_r(in_001_r), .in_001_i(in_001_i), .in_100_r(in_100_r), .in_100_i(in_100_i),
    .in_011_r(in_011_r), .in_011_i(in_011_i), .in_110_r(in_110_r), .in_110_i(in_110_i),
    .out_valid(out_valid),
    .out_001_r(out_001_r), .out_001_i(out_001_i), .out_100_r(out_100_r), .out_100_i(out_100_i),
    .out_011_r(out_011_r), .out_011_i(out_011_i), .out_110_r(out_110_r), .out_110_i(out_110_i)
  );

  function automatic vec_t mk(input int r001, i001, r100, i100, r011, i011, r110, i110);
    vec_t v;
    v.a001_r = W'(r001); v.a001_i = W'(i001); v.a100_r = W'(r100); v.a100_i = W'(i100);
    v.a011_r = W'(r011); v.a011_i = W'(i011); v.a110_r = W'(r110); v.a110_i = W'(i110);
    return v;
  endfunction

  // Reference model: what the output registers should hold after accepting v.
  function automatic vec_t swapped(input vec_t v);
    vec_t s;
    s.a001_r = v.a100_r; s.a001_i = v.a100_i; s.a100_r = v.a001_r; s.a100_i = v.a001_i;
    s.a011_r = v.a110_r; s.a011_i = v.a110_i; s.a110_r = v.a011_r; s.a110_i = v.a011_i;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic vld_exp, input vec_t e);
    checks++;
    assert (out_valid === vld_exp) else begin
      errors++;
      $error("FAIL %s.valid observed=%b expected=%b", tag, out_valid, vld_exp);
    end
    chk({tag, ".001r"}, out_001_r, e.a001_r);
    chk({tag, ".001i"}, out_001_i, e.a001_i);
    chk({tag, ".100r"}, out_100_r, e.a100_r);
    chk({tag, ".100i"}, out_100_i, e.a100_i);
    chk({tag, ".011r"}, out_011_r, e.a011_r);
    chk({tag, ".011i"}, out_011_i, e.a011_i);
    chk({tag, ".110r"}, out_110_r, e.a110_r);
    chk({tag, ".110i"}, out_110_i, e.a110_i);
  endtask

  task automatic drive(input vec_t v, input logic vld);
    in_001_r = v.a001_r; in_001_i = v.a001_i; in_100_r = v.a100_r; in_100_i = v.a100_i;
    in_011_r = v.a011_r; in_011_i = v.a011_i; in_110_r = v.a110_r; in_110_i = v.a110_i;
    in_valid = vld;
    if (vld) exp_q.push_back(swapped(v));
  endtask

  // One clock edge, then compare against the scoreboard (or the hold model when idle).
  task automatic step(input string tag, input vec_t v, input logic vld);
    vec_t e;
    drive(v, vld);
    @(posedge clk);
    #1;
    if (vld) begin
      if (exp_q.size() == 0) begin
        errors++; checks++;
        $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        e = last_out;
      end else begin
        e = exp_q.pop_front();
      end
      last_out = e;
    end else begin
      e = last_out;
    end
    chk_out(tag, vld, e);
  endtask

  task automatic assert_reset_now(input string tag);
    rst = 1'b1;
    exp_q.delete();
    last_out = '0;
    #1;
    chk_out(tag, 1'b0, '0);
  endtask

  localparam int MAXV = (1 << (W-1)) - 1;
  localparam int MINV = -(1 << (W-1));

  initial begin
    vec_t va, vb, vc;
    last_out = '0;
    // Reset with live, valid inputs, before any clock edge.
    drive(mk(1, 2, 3, 4, 5, 6, 7, 8), 1'b1);
    exp_q.delete();
    #1;
    assert_reset_now("reset_async");
    @(posedge clk); #1;
    chk_out("reset_held", 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;

    step("basic", mk(8, 0, -8, 0, 0, 8, 0, -8), 1'b1);
    step("hold", mk(100, 200, 300, 400, 500, 600, 700, 800), 1'b0);
    step("extremes", mk(MAXV, MINV, MINV, MAXV, MINV, MINV, MAXV, MAXV), 1'b1);
    step("lanes", mk(16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 16'h0f0f, 16'hf0f0, 16'h00ff, 16'hff00), 1'b1);

    va = mk(1, -1, 2, -2, 3, -3, 4, -4);
    vb = mk(-5, 5, -6, 6, -7, 7, -8, 8);
    vc = mk(int'($urandom), int'($urandom), int'($urandom), int'($urandom),
            int'($urandom), int'($urandom), int'($urandom), int'($urandom));
    step("stream_a", va, 1'b1);
    step("stream_b", vb, 1'b1);
    step("stream_c", vc, 1'b1);
    step("stream_idle", vb, 1'b0);

    // Mid-stream reset: vector B is presented but reset lands before its edge.
    step("mid_a", va, 1'b1);
    drive(vb, 1'b1);
    #2;
    assert_reset_now("mid_reset");
    @(posedge clk); #1;
    chk_out("mid_reset_held", 1'b0, '0);
    @(negedge clk);
    rst = 1'b0;
    step("mid_after", vc, 1'b1);
    step("mid_after2", va, 1'b1);
    step("final_idle", vb, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
